// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and decode handshake.
// Optional stall cycle counter is built only when PERF_CNT_EN is defined.
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [12:0] id_ctrl,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm,
   input  logic [31:0] id_pc4,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        flush,
   input  logic        ex_ready,
   output logic        ex_valid,
   output logic [12:0] ex_ctrl,
   output logic [31:0] ex_rs_data,
   output logic [31:0] ex_rt_data,
   output logic [31:0] ex_imm,
   output logic [31:0] ex_pc4,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_rd,
   output logic        load_use_stall
`ifdef PERF_CNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   // state | meaning
   // EMPTY | no instruction held, ex_ctrl forced to 0
   // FULL  | instruction held for the execute stage
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [12:0] ctrl_q, ctrl_d;
   logic [31:0] rs_data_q, rs_data_d;
   logic [31:0] rt_data_q, rt_data_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] pc4_q, pc4_d;
   logic [4:0]  rs_q, rs_d;
   logic [4:0]  rt_q, rt_d;
   logic [4:0]  rd_q, rd_d;
   logic        take;

   assign load_use_stall = (state_q == FULL) & ctrl_q[6] & (rt_q != 5'd0) & id_valid &
                           ((rt_q == id_rs) | (rt_q == id_rt));
   assign id_ready = ((state_q == EMPTY) | ex_ready) & ~load_use_stall & ~flush;
   assign take     = id_valid & id_ready;

   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      pc4_d     = pc4_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      if (flush) begin
         state_d = EMPTY;
         ctrl_d  = '0;
      end else if (take) begin
         state_d   = FULL;
         ctrl_d    = id_ctrl;
         rs_data_d = id_rs_data;
         rt_data_d = id_rt_data;
         imm_d     = id_imm;
         pc4_d     = id_pc4;
         rs_d      = id_rs;
         rt_d      = id_rt;
         rd_d      = id_rd;
      end else if ((state_q == FULL) && ex_ready) begin
         // covers both a plain drain and a load-use bubble
         state_d = EMPTY;
         ctrl_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= EMPTY;
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc4_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         pc4_q     <= pc4_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
      end
   end

   assign ex_valid   = (state_q == FULL);
   assign ex_ctrl    = ctrl_q;
   assign ex_rs_data = rs_data_q;
   assign ex_rt_data = rt_data_q;
   assign ex_imm     = imm_q;
   assign ex_pc4     = pc4_q;
   assign ex_rs      = rs_q;
   assign ex_rt      = rt_q;
   assign ex_rd      = rd_q;

`ifdef PERF_CNT_EN
   logic [15:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (load_use_stall && (stall_count_q != 16'hFFFF))
         stall_count_d = stall_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_count_q <= '0;
      else       stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage against a transaction-level model of the stage.
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        reset, id_valid, flush, ex_ready;
   logic        id_ready, ex_valid, load_use_stall;
   logic [12:0] id_ctrl, ex_ctrl;
   logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
   logic [4:0]  id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_rd;
`ifdef PERF_CNT_EN
   logic [15:0] stall_count;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
      .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .load_use_stall(load_use_stall)
`ifdef PERF_CNT_EN
      , .stall_count(stall_count)
`endif
   );

   // Reference: the instruction currently held (if any) plus the stall tally.
   typedef struct {
      logic        v;
      logic [12:0] ctrl;
      logic [31:0] rsd, rtd, imm, pc4;
      logic [4:0]  rs, rt, rd;
   } instr_t;

   instr_t m;
   int     m_cnt = 0;

   function automatic logic exp_stall();
      return m.v && m.ctrl[6] && (m.rt != 5'd0) && id_valid && (m.rt == id_rs || m.rt == id_rt);
   endfunction

   function automatic logic exp_ready();
      return (!m.v || ex_ready) && !exp_stall() && !flush;
   endfunction

   // Advance the model by one clock edge using the inputs presented now, then wait for the edge.
   task automatic tick();
      instr_t nx;
      int     nc;
      nx = m;
      nc = m_cnt;
      if (exp_stall() && nc < 65535) nc = nc + 1;
      if (reset) begin
         nx = '{v: 1'b0, ctrl: '0, rsd: '0, rtd: '0, imm: '0, pc4: '0, rs: '0, rt: '0, rd: '0};
         nc = 0;
      end else if (flush) begin
         nx.v = 1'b0; nx.ctrl = '0;
      end else if (id_valid && exp_ready()) begin
         nx = '{v: 1'b1, ctrl: id_ctrl, rsd: id_rs_data, rtd: id_rt_data, imm: id_imm,
                pc4: id_pc4, rs: id_rs, rt: id_rt, rd: id_rd};
      end else if (m.v && ex_ready) begin
         nx.v = 1'b0; nx.ctrl = '0;
      end
      @(posedge clk);
      #1;
      m = nx;
      m_cnt = nc;
   endtask

   task automatic drive_id(input logic [12:0] c, input logic [4:0] rs, input logic [4:0] rt);
      id_valid   = 1'b1;
      id_ctrl    = c;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = 5'($urandom);
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_imm     = $urandom;
      id_pc4     = $urandom;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
      drive_id(13'h0387, 5'd1, 5'd2);
      tick();
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 13'h0) begin
         bad++; $display("FAIL reset_state: got valid=%b ctrl=%h exp valid=0 ctrl=0", ex_valid, ex_ctrl);
      end
      total++;
      if (ex_rs_data !== 32'h0 || ex_rd !== 5'h0) begin
         bad++; $display("FAIL reset_fields: got rs_data=%h rd=%h exp 0", ex_rs_data, ex_rd);
      end
`ifdef PERF_CNT_EN
      total++;
      if (stall_count !== 16'h0) begin
         bad++; $display("FAIL reset_count: got %h exp 0", stall_count);
      end
`endif
   endtask

   task automatic test_pass_through();
      drive_id(13'h0387, 5'd3, 5'd4);
      id_rs_data = 32'h5;
      ex_ready = 1'b1;
      #1;
      total++;
      if (id_ready !== 1'b1) begin
         bad++; $display("FAIL pass_ready: got %b exp 1", id_ready);
      end
      tick();
      id_valid = 1'b0;
      total++;
      if (ex_valid !== 1'b1 || ex_ctrl !== 13'h0387 || ex_rs_data !== 32'h5) begin
         bad++; $display("FAIL pass_through: got v=%b ctrl=%h rsd=%h exp v=1 ctrl=0387 rsd=5",
                         ex_valid, ex_ctrl, ex_rs_data);
      end
      tick();
      total++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 13'h0) begin
         bad++; $display("FAIL drain_empty: got v=%b ctrl=%h exp v=0 ctrl=0", ex_valid, ex_ctrl);
      end
   endtask

   task automatic test_load_use();
      int base;
      drive_id(13'h03C0, 5'd2, 5'd8);
      ex_ready = 1'b1;
      tick();
      drive_id(13'h0387, 5'd8, 5'd9);
      base = m_cnt;
      #1;
      total++;
      if (load_use_stall !== 1'b1 || id_ready !== 1'b0) begin
         bad++; $display("FAIL lu_detect: got stall=%b ready=%b exp stall=1 ready=0", load_use_stall, id_ready);
      end
      tick();
      total++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 13'h0) begin
         bad++; $display("FAIL lu_bubble: got v=%b ctrl=%h exp v=0 ctrl=0", ex_valid, ex_ctrl);
      end
      total++;
      if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin
         bad++; $display("FAIL lu_clear: got stall=%b ready=%b exp stall=0 ready=1", load_use_stall, id_ready);
      end
      tick();
      id_valid = 1'b0;
      total++;
      if (ex_valid !== 1'b1 || ex_ctrl !== 13'h0387 || ex_rs !== 5'd8) begin
         bad++; $display("FAIL lu_capture: got v=%b ctrl=%h rs=%0d exp v=1 ctrl=0387 rs=8", ex_valid, ex_ctrl, ex_rs);
      end
`ifdef PERF_CNT_EN
      total++;
      if (stall_count !== 16'(base + 1)) begin
         bad++; $display("FAIL lu_count: got %0d exp %0d", stall_count, base + 1);
      end
`endif
      tick();
   endtask

   task automatic test_no_false_stall();
      drive_id(13'h03C0, 5'd5, 5'd0);
      ex_ready = 1'b1;
      tick();
      drive_id(13'h0387, 5'd0, 5'd0);
      #1;
      total++;
      if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin
         bad++; $display("FAIL no_false_stall: got stall=%b ready=%b exp stall=0 ready=1", load_use_stall, id_ready);
      end
      id_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_backpressure();
      drive_id(13'h1A5A, 5'd6, 5'd7);
      ex_ready = 1'b1;
      tick();
      ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_id(13'($urandom), 5'($urandom), 5'($urandom));
         #1;
         total++;
         if (id_ready !== 1'b0) begin
            bad++; $display("FAIL bp_ready[%0d]: got %b exp 0", i, id_ready);
         end
         tick();
         total++;
         if (ex_valid !== 1'b1 || ex_ctrl !== m.ctrl || ex_rs_data !== m.rsd || ex_rt_data !== m.rtd ||
             ex_imm !== m.imm || ex_pc4 !== m.pc4 || ex_rs !== m.rs || ex_rt !== m.rt || ex_rd !== m.rd) begin
            bad++; $display("FAIL bp_hold[%0d]: got ctrl=%h rsd=%h exp ctrl=%h rsd=%h", i, ex_ctrl, ex_rs_data, m.ctrl, m.rsd);
         end
      end
      total++;
      if (m.ctrl !== 13'h1A5A) begin
         bad++; $display("FAIL bp_model: got %h exp 1a5a", m.ctrl);
      end
      ex_ready = 1'b1;
      id_valid = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      drive_id(13'h0387, 5'd1, 5'd2);
      ex_ready = 1'b1;
      tick();
      drive_id(13'h0B87, 5'd3, 5'd4);
      flush = 1'b1;
      #1;
      total++;
      if (id_ready !== 1'b0) begin
         bad++; $display("FAIL flush_ready: got %b exp 0", id_ready);
      end
      tick();
      flush = 1'b0;
      id_valid = 1'b0;
      total++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 13'h0) begin
         bad++; $display("FAIL flush_squash: got v=%b ctrl=%h exp v=0 ctrl=0", ex_valid, ex_ctrl);
      end
      tick();
      total++;
      if (ex_valid !== 1'b0) begin
         bad++; $display("FAIL flush_not_taken: got v=%b exp 0", ex_valid);
      end
   endtask

   task automatic test_reset_mid_stall();
      drive_id(13'h03C0, 5'd1, 5'd12);
      ex_ready = 1'b0;
      tick();
      drive_id(13'h0387, 5'd12, 5'd3);
      #1;
      total++;
      if (load_use_stall !== 1'b1) begin
         bad++; $display("FAIL rst_stall_pre: got %b exp 1", load_use_stall);
      end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (load_use_stall !== 1'b0 || ex_valid !== 1'b0 || ex_ctrl !== 13'h0) begin
         bad++; $display("FAIL rst_stall_post: got stall=%b v=%b ctrl=%h exp 0 0 0", load_use_stall, ex_valid, ex_ctrl);
      end
`ifdef PERF_CNT_EN
      total++;
      if (stall_count !== 16'h0) begin
         bad++; $display("FAIL rst_stall_count: got %0d exp 0", stall_count);
      end
`endif
      id_valid = 1'b0;
      ex_ready = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 99) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         ex_ready = ($urandom_range(0, 3) != 0);
         drive_id(13'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         id_valid = ($urandom_range(0, 3) != 0);
         #1;
         total++;
         if (load_use_stall !== exp_stall() || id_ready !== exp_ready()) begin
            bad++; $display("FAIL rnd_comb[%0d]: got stall=%b ready=%b exp stall=%b ready=%b",
                            i, load_use_stall, id_ready, exp_stall(), exp_ready());
         end
         tick();
         total++;
         if (ex_valid !== m.v || ex_ctrl !== (m.v ? m.ctrl : 13'h0)) begin
            bad++; $display("FAIL rnd_state[%0d]: got v=%b ctrl=%h exp v=%b ctrl=%h", i, ex_valid, ex_ctrl, m.v, m.ctrl);
         end
         if (m.v) begin
            total++;
            if (ex_rs_data !== m.rsd || ex_rt_data !== m.rtd || ex_imm !== m.imm || ex_pc4 !== m.pc4 ||
                ex_rs !== m.rs || ex_rt !== m.rt || ex_rd !== m.rd) begin
               bad++; $display("FAIL rnd_fields[%0d]: got rsd=%h rt=%0d exp rsd=%h rt=%0d", i, ex_rs_data, ex_rt, m.rsd, m.rt);
            end
         end
`ifdef PERF_CNT_EN
         total++;
         if (stall_count !== 16'(m_cnt)) begin
            bad++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", i, stall_count, m_cnt);
         end
`endif
      end
      reset = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      m = '{v: 1'b0, ctrl: '0, rsd: '0, rtd: '0, imm: '0, pc4: '0, rs: '0, rt: '0, rd: '0};
      reset = 1'b1; flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
      id_ctrl = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_pc4 = '0;
      id_rs = '0; id_rt = '0; id_rd = '0;
      #2;
      test_reset();
      test_pass_through();
      test_load_use();
      test_no_false_stall();
      test_backpressure();
      test_flush();
      test_reset_mid_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
